game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter: FIRST_PLAYER, default 2'b01, cell code of the player who moves first after reset or new_game (legal values 2'b01 X, 2'b10 O).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 new_game  input  1  one-cycle request to clear the board and restart.
REQ-005 move_valid  input  1  move request strobe, sampled each cycle.
REQ-006 move_pos  input  4  target cell 0..8, row-major (0 top-left, 8 bottom-right).
REQ-007 win_in  input  1  OR of all eight external line detectors (3 rows, 3 columns, 2 diagonals) driven from board.
REQ-008 win_who  input  2  winning cell code from those detectors (01 X, 10 O).
REQ-009 board  output  18  cell k occupies bits [2k+1:2k]; 00 empty, 01 X, 10 O; 11 is never driven.
REQ-010 turn  output  2  cell code of the player to move; 00 whenever the game is over.
REQ-011 move_ack  output  1  one-cycle pulse, move accepted.
REQ-012 move_err  output  1  one-cycle pulse, move rejected.
REQ-013 game_over  output  1  high while in state OVER.
REQ-014 result  output  2  00 in play, 01 X won, 10 O won, 11 draw.

Function
REQ-015 The FSM SHALL have exactly three states: PLAY, CHECK, OVER.
REQ-016 In PLAY, a move with move_valid=1, move_pos<=8 and the target cell 00 SHALL write turn into that cell at the next edge, pulse move_ack in that same next cycle, increment move_cnt (4 bits, range 0..9) and go to CHECK.
REQ-017 In PLAY, move_pos>8 or an occupied target cell SHALL pulse move_err the next cycle, leave board, turn and move_cnt unchanged, and stay in PLAY.
REQ-018 In CHECK, the FSM SHALL sample win_in and win_who, which are combinational from the already-updated board.
REQ-019 In CHECK with win_in=1, the FSM SHALL set result=win_who and go to OVER.
REQ-020 In CHECK with win_in=0 and move_cnt=9, the FSM SHALL set result=11 and go to OVER.
REQ-021 In CHECK with win_in=0 and move_cnt<9, the FSM SHALL toggle turn (01<->10) and return to PLAY.
REQ-022 Total latency is 2 cycles from an accepted move_valid to the next move being accepted.
REQ-023 move_valid in CHECK or OVER SHALL pulse move_err and SHALL NOT modify any state.
REQ-024 A win on the ninth move SHALL report the winner, not a draw.
REQ-025 new_game in any state SHALL, at the next edge, clear board to 0, set move_cnt=0, result=00, turn=FIRST_PLAYER, and state=PLAY.
REQ-026 If new_game and move_valid are asserted together, new_game SHALL win: the move is ignored and neither move_ack nor move_err pulses.
REQ-027 move_ack and move_err SHALL never be high in the same cycle.
REQ-028 All outputs SHALL be registered, except turn, which is decoded from the state and the turn register.

Reset
REQ-029 With reset=1 at an edge: board=0, move_cnt=0, result=00, state=PLAY, turn=FIRST_PLAYER, move_ack=0, move_err=0, game_over=0.
REQ-030 reset SHALL take priority over new_game and move_valid, and SHALL discard any in-progress CHECK without sampling win_in.

Structure
REQ-031 A shared package ttt_pkg SHALL hold: the cell codes (EMPTY=00, PX=01, PO=10); the result codes (NONE, XWIN, OWIN, DRAW); the state enum {PLAY, CHECK, OVER}; and the constant NCELLS=9.
REQ-032 One sub-module, board_reg, SHALL hold the nine 2-bit cells, provide write-enable, position and clear, and expose the per-cell occupied flags.
REQ-033 Line detection SHALL stay outside this block; the bench SHALL model it with eight 3-cell equality checkers on board.

Verification
REQ-034 X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 -> after the final CHECK, result=01, game_over=1, turn=00.
REQ-035 After X plays cell 4, a move to 4 -> move_err pulse, board unchanged, turn still 10; then a move to 9 -> move_err again.
REQ-036 Sequence 0X 1O 2X 4O 3X 5O 7X 6O 8X (no line complete) -> result=11 after the 9th CHECK; the same sequence altered to complete a line on move 9 -> winner reported.
REQ-037 move_valid in the cycle right after move_ack (state CHECK) -> move_err, move_cnt unchanged; and new_game+move_valid together -> board=0, no ack/err.
REQ-038 reset asserted in CHECK with win_in forced to 1 -> result=00, board=0, state PLAY; FIRST_PLAYER=10 -> turn=10 after reset.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game controller.
//   - cell codes stored in the board and used for the player to move
//   - result codes reported once a game has ended
//   - controller state enum
//   - board geometry constant and a small helper to swap players
package ttt_pkg;

    // Cell contents (also used as player identity).
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] PX    = 2'b01;
    localparam logic [1:0] PO    = 2'b10;

    // Game outcome codes; XWIN/OWIN deliberately match the PX/PO cell codes
    // so a detected winner's cell code can be reported directly.
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] XWIN = 2'b01;
    localparam logic [1:0] OWIN = 2'b10;
    localparam logic [1:0] DRAW = 2'b11;

    // Number of cells on the 3x3 board.
    localparam int unsigned NCELLS = 9;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    // Player who moves after p. Anything other than PX maps to PX so a
    // corrupted turn register recovers to a legal code.
    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == PX) ? PO : PX;
    endfunction

endpackage

// File: rtl/board_reg.sv
// board_reg: storage for the nine 2-bit cells of the game board.
//
// Ports
//   clk_i       rising-edge clock
//   clear_i     synchronous clear of every cell to EMPTY (highest priority)
//   we_i        write enable for a single cell
//   pos_i       cell index 0..8 to write; indices above 8 are ignored
//   cell_i      code written into the addressed cell
//   board_o     packed board, cell k in bits [2k+1:2k]
//   occupied_o  per-cell flag, high when the cell is not EMPTY
module board_reg
    import ttt_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  clear_i,
    input  logic                  we_i,
    input  logic [3:0]            pos_i,
    input  logic [1:0]            cell_i,
    output logic [2*NCELLS-1:0]   board_o,
    output logic [NCELLS-1:0]     occupied_o
);

    logic [1:0] cells_q [NCELLS];

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int k = 0; k < NCELLS; k++) begin
                cells_q[k] <= EMPTY;
            end
        end else if (we_i) begin
            // Compare against each index so an out-of-range pos_i writes nothing.
            for (int k = 0; k < NCELLS; k++) begin
                if (pos_i == 4'(k)) begin
                    cells_q[k] <= cell_i;
                end
            end
        end
    end

    always_comb begin
        board_o    = '0;
        occupied_o = '0;
        for (int k = 0; k < NCELLS; k++) begin
            board_o[2*k +: 2] = cells_q[k];
            occupied_o[k]     = (cells_q[k] != EMPTY);
        end
    end

endmodule

// File: rtl/game_controller.sv
// game_controller: turn sequencing and rule enforcement for tic-tac-toe.
// Line detection lives outside; win_in/win_who are combinational from board
// and are sampled one cycle after a move lands (state CHECK).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset (priority over everything)
//   new_game   one-cycle request to clear the board and restart
//   move_valid move request strobe
//   move_pos   target cell 0..8, row-major
//   win_in     OR of the eight external line detectors
//   win_who    winning cell code from the detectors
//   board      packed board, cell k in bits [2k+1:2k]
//   turn       player to move, 00 while the game is over
//   move_ack   one-cycle pulse, move accepted
//   move_err   one-cycle pulse, move rejected
//   game_over  high while in OVER
//   result     00 in play, 01 X won, 10 O won, 11 draw
module game_controller
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         new_game,
    input  logic         move_valid,
    input  logic [3:0]   move_pos,
    input  logic         win_in,
    input  logic [1:0]   win_who,
    output logic [17:0]  board,
    output logic [1:0]   turn,
    output logic         move_ack,
    output logic         move_err,
    output logic         game_over,
    output logic [1:0]   result
);

    localparam logic [3:0] LAST_POS  = 4'(NCELLS - 1);
    localparam logic [3:0] MAX_MOVES = 4'(NCELLS);

    state_t       state_q, state_d;
    logic [1:0]   player_q, player_d;
    logic [3:0]   move_cnt_q, move_cnt_d;
    logic [1:0]   result_q, result_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         over_q, over_d;

    logic               board_clear;
    logic               board_we;
    logic [NCELLS-1:0]  occupied;
    logic               pos_in_range;
    logic               target_busy;

    board_reg u_board (
        .clk_i      (clk),
        .clear_i    (board_clear),
        .we_i       (board_we),
        .pos_i      (move_pos),
        .cell_i     (player_q),
        .board_o    (board),
        .occupied_o (occupied)
    );

    // Occupancy of the addressed cell, selected without indexing past cell 8.
    always_comb begin
        pos_in_range = (move_pos <= LAST_POS);
        target_busy  = 1'b0;
        for (int k = 0; k < NCELLS; k++) begin
            if (move_pos == 4'(k)) begin
                target_busy = occupied[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        move_cnt_d  = move_cnt_q;
        result_d    = result_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        board_we    = 1'b0;
        board_clear = reset | new_game;

        if (new_game) begin
            // A simultaneous move is dropped silently: no ack, no err.
            state_d    = PLAY;
            player_d   = FIRST_PLAYER;
            move_cnt_d = '0;
            result_d   = NONE;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (move_valid) begin
                        if (pos_in_range && !target_busy) begin
                            board_we   = 1'b1;
                            ack_d      = 1'b1;
                            move_cnt_d = move_cnt_q + 4'd1;
                            state_d    = CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                CHECK: begin
                    err_d = move_valid;
                    // Win is tested before the draw so a ninth-move win is reported.
                    if (win_in) begin
                        result_d = win_who;
                        state_d  = OVER;
                    end else if (move_cnt_q == MAX_MOVES) begin
                        result_d = DRAW;
                        state_d  = OVER;
                    end else begin
                        player_d = other_player(player_q);
                        state_d  = PLAY;
                    end
                end

                OVER: begin
                    err_d = move_valid;
                end

                default: begin
                    state_d = PLAY;
                end
            endcase
        end

        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PLAY;
            player_q   <= FIRST_PLAYER;
            move_cnt_q <= '0;
            result_q   <= NONE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            player_q   <= player_d;
            move_cnt_q <= move_cnt_d;
            result_q   <= result_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            over_q     <= over_d;
        end
    end

    assign turn      = (state_q == OVER) ? EMPTY : player_q;
    assign move_ack  = ack_q;
    assign move_err  = err_q;
    assign game_over = over_q;
    assign result    = result_q;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

    logic        clk = 1'b0;
    logic        reset, new_game, move_valid;
    logic [3:0]  move_pos;
    logic        win_in, win_who_dummy;
    logic [1:0]  win_who;
    logic [17:0] board;
    logic [1:0]  turn, result;
    logic        move_ack, move_err, game_over;

    // Second instance starting with O; it only sees reset/new_game.
    logic        mv2;
    logic [3:0]  pos2;
    logic        win2;
    logic [1:0]  who2;
    logic [17:0] board2;
    logic [1:0]  turn2, result2;
    logic        ack2, err2, over2;

    logic        force_win;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    game_controller dut (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .win_in(win_in), .win_who(win_who), .board(board),
        .turn(turn), .move_ack(move_ack), .move_err(move_err),
        .game_over(game_over), .result(result)
    );

    game_controller #(.FIRST_PLAYER(2'b10)) dut_o (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(mv2),
        .move_pos(pos2), .win_in(win2), .win_who(who2), .board(board2),
        .turn(turn2), .move_ack(ack2), .move_err(err2),
        .game_over(over2), .result(result2)
    );

    // External line detectors: eight 3-cell equality checkers.
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [2:0] detect(input logic [17:0] b);
        logic [2:0] r;
        logic [1:0] a, c, d;
        r = 3'b000;
        for (int l = 0; l < 8; l++) begin
            a = b[2*lines[l][0] +: 2];
            c = b[2*lines[l][1] +: 2];
            d = b[2*lines[l][2] +: 2];
            if (a != 2'b00 && a == c && c == d) r = {1'b1, a};
        end
        return r;
    endfunction

    always_comb begin
        logic [2:0] d1, d2;
        d1 = detect(board);
        d2 = detect(board2);
        win_in  = d1[2] | force_win;
        win_who = force_win ? 2'b01 : d1[1:0];
        win2    = d2[2];
        who2    = d2[1:0];
    end

    assign win_who_dummy = 1'b0;

    // Reference model: game-level view of the board and outcome.
    int  m_cell [9];
    int  m_player;      // 1 = X, 2 = O
    int  m_first;
    int  m_moves;
    int  m_result;      // 0 none, 1 X, 2 O, 3 draw
    bit  m_over;
    bit  m_judging;     // a move landed last cycle, outcome not yet published
    bit  e_ack, e_err;

    function automatic bit has_three(input int p);
        bit w;
        w = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_cell[3*i] == p && m_cell[3*i+1] == p && m_cell[3*i+2] == p) w = 1;
            if (m_cell[i] == p && m_cell[i+3] == p && m_cell[i+6] == p) w = 1;
        end
        if (m_cell[0] == p && m_cell[4] == p && m_cell[8] == p) w = 1;
        if (m_cell[2] == p && m_cell[4] == p && m_cell[6] == p) w = 1;
        return w;
    endfunction

    task automatic model_step(input bit rst, input bit ng, input bit mv, input int pos);
        e_ack = 0;
        e_err = 0;
        if (rst || ng) begin
            foreach (m_cell[k]) m_cell[k] = 0;
            m_player = m_first; m_moves = 0; m_result = 0; m_over = 0; m_judging = 0;
        end else if (m_judging) begin
            e_err = mv;
            m_judging = 0;
            if (has_three(m_player)) begin
                m_over = 1; m_result = m_player;
            end else if (m_moves == 9) begin
                m_over = 1; m_result = 3;
            end else begin
                m_player = 3 - m_player;
            end
        end else if (m_over) begin
            e_err = mv;
        end else if (mv) begin
            if (pos < 9 && m_cell[pos] == 0) begin
                m_cell[pos] = m_player; m_moves++; e_ack = 1; m_judging = 1;
            end else begin
                e_err = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit ng, input bit mv, input int pos);
        logic [17:0] eb;
        reset = rst; new_game = ng; move_valid = mv; move_pos = 4'(pos);
        model_step(rst, ng, mv, pos);
        @(posedge clk);
        #1;
        eb = '0;
        for (int k = 0; k < 9; k++) eb[2*k +: 2] = 2'(m_cell[k]);
        chk("board", 32'(board), 32'(eb));
        chk("turn", 32'(turn), m_over ? 0 : m_player);
        chk("move_ack", 32'(move_ack), 32'(e_ack));
        chk("move_err", 32'(move_err), 32'(e_err));
        chk("game_over", 32'(game_over), 32'(m_over));
        chk("result", 32'(result), m_result);
        chk("ack_err_excl", 32'(move_ack & move_err), 0);
        reset = 0; new_game = 0; move_valid = 0;
    endtask

    // One accepted move plus its judging cycle.
    task automatic play(input int pos);
        cyc(0, 0, 1, pos);
        cyc(0, 0, 0, 0);
    endtask

    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_win9 [9] = '{0, 1, 2, 4, 3, 5, 7, 8, 6};

    initial begin
        m_first = 1;
        force_win = 0;
        mv2 = 0; pos2 = '0;
        reset = 0; new_game = 0; move_valid = 0; move_pos = '0;

        // Reset state, both instances.
        cyc(1, 0, 0, 0);
        chk("reset_turn_o", 32'(turn2), 32'h2);
        chk("reset_board_o", 32'(board2), 0);

        // X wins top row.
        play(0); play(3); play(1); play(4); play(2);
        chk("xwin_result", 32'(result), 32'h1);
        chk("xwin_over", 32'(game_over), 1);
        chk("xwin_turn", 32'(turn), 0);
        cyc(0, 0, 1, 5);                     // move while over

        // Occupied target and out-of-range target.
        cyc(0, 1, 0, 0);
        play(4);
        cyc(0, 0, 1, 4);
        chk("occ_turn", 32'(turn), 32'h2);
        cyc(0, 0, 1, 9);

        // Move during CHECK, then new_game together with a move.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 2);
        chk("ng_turn_o", 32'(turn2), 32'h2);

        // Full-board draw, then the same game ending in a ninth-move win.
        foreach (seq_draw[i]) play(seq_draw[i]);
        chk("draw_result", 32'(result), 32'h3);
        cyc(0, 1, 0, 0);
        foreach (seq_win9[i]) play(seq_win9[i]);
        chk("win9_result", 32'(result), 32'h1);

        // Reset during CHECK with the detectors forced high.
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 4);
        force_win = 1;
        cyc(1, 0, 0, 0);
        force_win = 0;
        chk("rst_check_result", 32'(result), 0);
        chk("rst_check_board", 32'(board), 0);

        // Randomized games.
        for (int g = 0; g < 25; g++) begin
            cyc(0, 1, 0, 0);
            for (int c = 0; c < 50; c++) begin
                int r;
                r = $urandom_range(0, 99);
                cyc(r == 0, (r >= 1 && r <= 2), ($urandom_range(0, 9) < 7),
                    $urandom_range(0, 11));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
